// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86-64 data-memory responder: instruction codes
// that generate memory traffic, the ADR status code, default geometry, the
// responder FSM state type and the address range helper.
package y86_mem_pkg;

    // Instruction codes that reach the data memory
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Processor status raised when rsp_error comes back set
    localparam logic [2:0] STAT_ADR = 3'd3;

    // Default geometry and timing
    localparam int DEFAULT_DEPTH   = 1024;
    localparam int DEFAULT_LATENCY = 2;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Full 64-bit range check: any nonzero upper bit makes the address
    // invalid, so a wide address never aliases onto a real word.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input int unsigned depth);
        return (addr < 64'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the memory stage (master) and
// the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port 64-bit RAM: synchronous write, asynchronous read on the shared
// port, plus an independent asynchronous debug read port. Contents are not
// reset.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    input  logic [AW-1:0] dbg_addr,
    output logic [63:0]   dbg_data
);

    logic [63:0] mem_r [DEPTH];

    // Write port: store on the commit edge only
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata    = mem_r[addr];
    assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits a fixed
// latency, commits the access to the array and presents the response until
// the requester takes it. Out-of-range addresses return rsp_error and never
// touch the array.
module dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                clk,
    input  logic                rst,
    dmem_responder_if.slave     bus,
    input  logic [63:0]         dbg_addr,
    output logic [63:0]         dbg_data
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_e state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic        write_r, write_nxt_s;
    logic [63:0] addr_r, addr_nxt_s;
    logic [63:0] wdata_r, wdata_nxt_s;
    logic        req_ready_r, rsp_valid_r, rsp_error_r;
    logic [63:0] rsp_rdata_r;
    logic [63:0] rdata_nxt_s;
    logic        error_nxt_s;
    logic        commit_s;

    // Transaction being committed: taken straight from the bus when the
    // commit happens on the acceptance edge (LATENCY == 1), else from the
    // latched copy.
    logic        cur_write_s;
    logic [63:0] cur_addr_s;
    logic [63:0] cur_wdata_s;
    logic        cur_in_range_s;
    logic        arr_we_s;
    logic [63:0] arr_rdata_s;
    logic [63:0] arr_dbg_s;
    logic        dbg_in_range_s;

    // Select the transaction fields feeding the array and range check
    always_comb begin
        if (state_r == IDLE) begin
            cur_write_s = bus.req_write;
            cur_addr_s  = bus.req_addr;
            cur_wdata_s = bus.req_wdata;
        end else begin
            cur_write_s = write_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
    end

    assign cur_in_range_s = addr_in_range(cur_addr_s, DEPTH);
    assign dbg_in_range_s = addr_in_range(dbg_addr, DEPTH);
    // A reset on the commit edge cancels the write
    assign arr_we_s = commit_s & cur_write_s & cur_in_range_s & ~rst;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk      (clk),
        .we       (arr_we_s),
        .addr     (cur_addr_s[AW-1:0]),
        .wdata    (cur_wdata_s),
        .rdata    (arr_rdata_s),
        .dbg_addr (dbg_addr[AW-1:0]),
        .dbg_data (arr_dbg_s)
    );

    assign dbg_data = dbg_in_range_s ? arr_dbg_s : 64'd0;

    // Next-state, latency counter, latch and response computation
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        write_nxt_s = write_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        rdata_nxt_s = rsp_rdata_r;
        error_nxt_s = rsp_error_r;
        commit_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    write_nxt_s = bus.req_write;
                    addr_nxt_s  = bus.req_addr;
                    wdata_nxt_s = bus.req_wdata;
                    cnt_nxt_s   = LAT_M1;
                    if (LAT_M1 != 4'd0) begin
                        state_nxt_s = WAIT;
                    end else begin
                        commit_s    = 1'b1;
                        state_nxt_s = RESP;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    commit_s    = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rdata_nxt_s = 64'd0;
                    error_nxt_s = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (commit_s) begin
            if (!cur_in_range_s) begin
                rdata_nxt_s = 64'd0;
                error_nxt_s = 1'b1;
            end else if (cur_write_s) begin
                rdata_nxt_s = 64'd0;
                error_nxt_s = 1'b0;
            end else begin
                rdata_nxt_s = arr_rdata_s;
                error_nxt_s = 1'b0;
            end
        end else begin
            commit_s = 1'b0;
        end
    end

    // State and registered outputs; reset abandons any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            write_r     <= 1'b0;
            addr_r      <= 64'd0;
            wdata_r     <= 64'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 64'd0;
            rsp_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            write_r     <= write_nxt_s;
            addr_r      <= addr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            rsp_rdata_r <= rdata_nxt_s;
            rsp_error_r <= error_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_error = rsp_error_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) driven by
// directed steps plus randomized transactions, checked against a word-array
// reference model.
module tb_dmem_responder;

    function automatic int lat(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid_d [3];
    logic        req_write_d [3];
    logic [63:0] req_addr_d  [3];
    logic [63:0] req_wdata_d [3];
    logic        rsp_ready_d [3];
    logic [63:0] dbg_addr_d  [3];
    logic        req_ready_m [3];
    logic        rsp_valid_m [3];
    logic [63:0] rsp_rdata_m [3];
    logic        rsp_error_m [3];
    logic [63:0] dbg_data_m  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder_if bus();
        assign bus.req_valid  = req_valid_d[g];
        assign bus.req_write  = req_write_d[g];
        assign bus.req_addr   = req_addr_d[g];
        assign bus.req_wdata  = req_wdata_d[g];
        assign bus.rsp_ready  = rsp_ready_d[g];
        assign req_ready_m[g] = bus.req_ready;
        assign rsp_valid_m[g] = bus.rsp_valid;
        assign rsp_rdata_m[g] = bus.rsp_rdata;
        assign rsp_error_m[g] = bus.rsp_error;

        dmem_responder #(
            .DEPTH   (1024),
            .LATENCY (lat(g))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .dbg_addr (dbg_addr_d[g]),
            .dbg_data (dbg_data_m[g])
        );
    end

    // Reference model: committed contents per instance, with a known flag
    // because the array is never cleared.
    logic [63:0] model [3][1024];
    bit          known [3][1024];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned r;
        r = $urandom_range(9, 0);
        if (r <= 6)       return 64'($urandom_range(15, 0));
        else if (r == 7)  return 64'($urandom_range(1023, 1016));
        else if (r == 8)  return 64'($urandom_range(1030, 1024));
        else              return {$urandom, $urandom} | 64'h0000_0001_0000_0000;
    endfunction

    // One complete transaction with optional response back-pressure
    task automatic do_txn(input int d, input bit wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold,
                          output logic [63:0] got);
        logic        exp_err;
        logic [63:0] exp_rd;
        bit          chk_rd;
        int          cyc;
        logic [63:0] held;
        exp_err = (addr >= 64'd1024);
        exp_rd  = 64'd0;
        chk_rd  = 1'b1;
        if (!exp_err && !wr) begin
            if (known[d][addr[9:0]]) exp_rd = model[d][addr[9:0]];
            else chk_rd = 1'b0;
        end
        @(negedge clk);
        check("idle_ready", {63'd0, req_ready_m[d]}, 64'd1);
        req_valid_d[d] = 1'b1;
        req_write_d[d] = wr;
        req_addr_d[d]  = addr;
        req_wdata_d[d] = wdata;
        rsp_ready_d[d] = (hold == 0);
        dbg_addr_d[d]  = addr;
        @(negedge clk);
        req_valid_d[d] = 1'b0;
        cyc = 1;
        while (!rsp_valid_m[d] && cyc < 40) begin
            check("wait_busy", {63'd0, req_ready_m[d]}, 64'd0);
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat(d)));
        check("rsp_error", {63'd0, rsp_error_m[d]}, {63'd0, exp_err});
        if (chk_rd) check("rsp_rdata", rsp_rdata_m[d], exp_rd);
        got = rsp_rdata_m[d];
        if (!exp_err && wr) begin
            model[d][addr[9:0]] = wdata;
            known[d][addr[9:0]] = 1'b1;
        end
        if (exp_err) check("dbg_oob", dbg_data_m[d], 64'd0);
        else if (known[d][addr[9:0]]) check("dbg_commit", dbg_data_m[d], model[d][addr[9:0]]);
        held = rsp_rdata_m[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, rsp_valid_m[d]}, 64'd1);
            check("bp_stable", rsp_rdata_m[d], held);
            check("bp_ready", {63'd0, req_ready_m[d]}, 64'd0);
        end
        rsp_ready_d[d] = 1'b1;
        @(negedge clk);
        check("done_valid", {63'd0, rsp_valid_m[d]}, 64'd0);
        check("done_rdata", rsp_rdata_m[d], 64'd0);
        check("done_ready", {63'd0, req_ready_m[d]}, 64'd1);
        rsp_ready_d[d] = 1'b0;
    endtask

    // req_valid held high: accepts must be LATENCY+1 cycles apart
    task automatic throughput(input int d);
        int acc[$];
        int l;
        int n;
        l = lat(d);
        @(negedge clk);
        req_valid_d[d] = 1'b1;
        req_write_d[d] = 1'b0;
        req_addr_d[d]  = 64'd0;
        rsp_ready_d[d] = 1'b1;
        for (int c = 0; c <= 4 * (l + 1); c++) begin
            if (req_ready_m[d]) acc.push_back(c);
            @(negedge clk);
        end
        req_valid_d[d] = 1'b0;
        check("tp_count", 64'(acc.size()), 64'd5);
        for (int i = 1; i < acc.size(); i++) begin
            check("tp_gap", 64'(acc[i] - acc[i-1]), 64'(l + 1));
        end
        n = 0;
        while (!(req_ready_m[d] && !rsp_valid_m[d]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tp_drain", {63'd0, (n < 40)}, 64'd1);
        rsp_ready_d[d] = 1'b0;
    endtask

    initial begin
        logic [63:0] got;
        for (int d = 0; d < 3; d++) begin
            req_valid_d[d] = 1'b0;
            req_write_d[d] = 1'b0;
            req_addr_d[d]  = 64'd0;
            req_wdata_d[d] = 64'd0;
            rsp_ready_d[d] = 1'b0;
            dbg_addr_d[d]  = 64'd0;
            for (int a = 0; a < 1024; a++) known[d][a] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("rst_req_ready", {63'd0, req_ready_m[d]}, 64'd1);
            check("rst_rsp_valid", {63'd0, rsp_valid_m[d]}, 64'd0);
            check("rst_rsp_rdata", rsp_rdata_m[d], 64'd0);
            check("rst_rsp_error", {63'd0, rsp_error_m[d]}, 64'd0);
        end

        // Write then read, LATENCY 2
        do_txn(0, 1'b1, 64'd5, 64'hDEAD_BEEF_0000_0001, 0, got);
        check("w5_rdata_zero", got, 64'd0);
        do_txn(0, 1'b0, 64'd5, 64'd0, 0, got);
        check("raw_5", got, 64'hDEAD_BEEF_0000_0001);

        // Back-pressure
        do_txn(0, 1'b0, 64'd5, 64'd0, 4, got);
        check("bp_read_5", got, 64'hDEAD_BEEF_0000_0001);

        // Address errors
        do_txn(0, 1'b1, 64'd1024, 64'd1, 0, got);
        check("err_1024_rdata", got, 64'd0);
        do_txn(0, 1'b1, 64'h1_0000_0005, 64'h1234, 0, got);
        @(negedge clk);
        dbg_addr_d[0] = 64'd5;
        #1;
        check("no_alias_5", dbg_data_m[0], 64'hDEAD_BEEF_0000_0001);

        // Reset on the commit edge of a write
        do_txn(0, 1'b1, 64'd7, 64'h77, 0, got);
        @(negedge clk);
        req_valid_d[0] = 1'b1;
        req_write_d[0] = 1'b1;
        req_addr_d[0]  = 64'd7;
        req_wdata_d[0] = 64'd9;
        dbg_addr_d[0]  = 64'd7;
        @(negedge clk);
        req_valid_d[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid", {63'd0, rsp_valid_m[0]}, 64'd0);
        check("rst_mid_ready", {63'd0, req_ready_m[0]}, 64'd1);
        check("rst_mid_mem7", dbg_data_m[0], 64'h77);
        @(negedge clk);
        check("rst_mid_novalid", {63'd0, rsp_valid_m[0]}, 64'd0);
        do_txn(0, 1'b0, 64'd7, 64'd0, 0, got);
        check("after_rst_read7", got, 64'h77);

        // LATENCY 1 and 15 instances
        do_txn(1, 1'b0, 64'd0, 64'd0, 0, got);
        do_txn(2, 1'b0, 64'd0, 64'd0, 1, got);
        for (int d = 0; d < 3; d++) throughput(d);

        // Stack-style sequence
        do_txn(0, 1'b1, 64'd1016, 64'h100, 0, got);
        do_txn(0, 1'b1, 64'd1008, 64'h2A, 0, got);
        do_txn(0, 1'b0, 64'd1008, 64'd0, 0, got);
        check("ret_1008", got, 64'h2A);
        do_txn(0, 1'b0, 64'd1016, 64'd0, 0, got);
        check("popq_1016", got, 64'h100);

        // Randomized transactions against the model
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 25; k++) begin
                do_txn(d, 1'($urandom_range(1, 0)), rand_addr(), {$urandom, $urandom},
                       int'($urandom_range(2, 0)), got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
